// File: rtl/mod_prod_pkg.sv
// mod_prod_pkg: shared state encoding and sizing helpers for the modular multiplier
package mod_prod_pkg;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    localparam int DEFAULT_WIDTH = 256;

    function automatic int k_width(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int calc_cycles(input int iters, input int bpc);
        return (iters + bpc - 1) / bpc;
    endfunction

endpackage

// File: rtl/mod_prod_step.sv
// mod_prod_step: one combinational shift-and-add iteration, m' = m + abit*t mod n, t' = 2t mod n
module mod_prod_step
    import mod_prod_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   m,
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] n,
    input  logic             abit,
    output logic [WIDTH:0]   m_next,
    output logic [WIDTH:0]   t_next
);

    logic [WIDTH:0] n_ext;
    logic [WIDTH:0] m_sum;
    logic [WIDTH:0] t_dbl;

    // one extra bit keeps m+t and 2t exact before the conditional subtract
    always_comb begin
        n_ext  = {1'b0, n};
        m_sum  = abit ? m + t : m;
        t_dbl  = t << 1;
        m_next = m_sum >= n_ext ? m_sum - n_ext : m_sum;
        t_next = t_dbl >= n_ext ? t_dbl - n_ext : t_dbl;
    end

endmodule

// File: rtl/modulo_product_seq.sv
// modulo_product_seq: iterative (a*b) mod N over a-bits 0..k; optional abort via MOD_PRODUCT_ABORT_EN
module modulo_product_seq
    import mod_prod_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int BITS_PER_CYCLE = 1,
    parameter int K_W            = k_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef MOD_PRODUCT_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [K_W-1:0]   k,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    state_e             state;
    state_e             state_n;
    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH:0]     m;
    logic [WIDTH:0]     t;
    logic [K_W:0]       cnt;
    logic [K_W-1:0]     kk;
    logic [WIDTH-1:0]   result_q;
    logic               abort_i;
    logic               calc_end;
    logic [WIDTH:0]     mc [BITS_PER_CYCLE+1];
    logic [WIDTH:0]     tc [BITS_PER_CYCLE+1];

`ifdef MOD_PRODUCT_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign calc_end = cnt > {1'b0, kk};
    assign ready    = state == S_IDLE;
    assign done     = state == S_DONE && !abort_i;
    assign result   = done ? m[WIDTH-1:0] : result_q;
    assign mc[0]    = m;
    assign tc[0]    = t;

    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
        logic [WIDTH:0] ms;
        logic [WIDTH:0] ts;
        logic           act;
        assign act = (cnt + (K_W+1)'(j)) <= {1'b0, kk};
        mod_prod_step #(.WIDTH(WIDTH)) u_step (
            .m      (mc[j]),
            .t      (tc[j]),
            .n      (n_q),
            .abit   (a_q[j]),
            .m_next (ms),
            .t_next (ts)
        );
        assign mc[j+1] = act ? ms : mc[j];
        assign tc[j+1] = act ? ts : tc[j];
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // next state; CALC spends one extra cycle noticing the last bit is consumed
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start ? S_CALC : S_IDLE;
            S_CALC:  state_n = abort_i ? S_IDLE : (calc_end ? S_DONE : S_CALC);
            default: state_n = S_IDLE;
        endcase
    end

    // datapath: latch on accept, iterate in CALC, commit result when leaving DONE cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= '0;
            a_q      <= '0;
            m        <= '0;
            t        <= '0;
            cnt      <= '0;
            kk       <= '0;
            result_q <= '0;
        end else if (state == S_IDLE && start) begin
            n_q <= N;
            a_q <= a;
            m   <= '0;
            t   <= {1'b0, b};
            cnt <= '0;
            kk  <= k > K_W'(WIDTH-1) ? K_W'(WIDTH-1) : k;
        end else if (state == S_CALC) begin
            m   <= mc[BITS_PER_CYCLE];
            t   <= tc[BITS_PER_CYCLE];
            a_q <= a_q >> BITS_PER_CYCLE;
            cnt <= cnt + (K_W+1)'(BITS_PER_CYCLE);
        end else if (done) begin
            result_q <= m[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_modulo_product_seq.sv
// tb_modulo_product_seq: scoreboard bench driving WIDTH=8 instances with 1 and 4 bits per cycle
module tb_modulo_product_seq;

    typedef struct {
        logic [7:0] res;
        int         due;
    } exp_t;

    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic [7:0] n = 0;
    logic [7:0] a = 0;
    logic [7:0] b = 0;
    logic [3:0] k = 0;
    logic       ready1, done1, ready4, done4;
    logic [7:0] result1, result4;
`ifdef MOD_PRODUCT_ABORT_EN
    logic       abort = 0;
`endif

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    modulo_product_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
`ifdef MOD_PRODUCT_ABORT_EN
        .abort(abort),
`endif
        .ready(ready1), .N(n), .a(a), .b(b), .k(k), .result(result1), .done(done1)
    );

    modulo_product_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start),
`ifdef MOD_PRODUCT_ABORT_EN
        .abort(abort),
`endif
        .ready(ready4), .N(n), .a(a), .b(b), .k(k), .result(result4), .done(done4)
    );

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int ref_mod(input int nn, input int aa, input int bb, input int kv);
        int kk;
        int am;
        kk = kv > 7 ? 7 : kv;
        am = aa & ((1 << (kk + 1)) - 1);
        return (am * bb) % nn;
    endfunction

    task automatic wait_idle();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(ready1 && ready4 && q1.size() == 0 && q4.size() == 0) && c < 400);
        chk("idle reached", int'(ready1 && ready4 && q1.size() == 0 && q4.size() == 0), 1);
    endtask

    task automatic issue(input int nn, input int aa, input int bb, input int kv);
        int   acc;
        int   kk;
        exp_t e;
        wait_idle();
        n = 8'(nn); a = 8'(aa); b = 8'(bb); k = 4'(kv);
        start = 1;
        @(posedge clk);
        #1;
        acc = cyc;
        kk = kv > 7 ? 7 : kv;
        e.res = 8'(ref_mod(nn, aa, bb, kv));
        e.due = acc + kk + 2;
        q1.push_back(e);
        e.due = acc + (kk + 4) / 4 + 1;
        q4.push_back(e);
        @(negedge clk);
        start = 0;
    endtask

    // monitor for the 1-bit-per-cycle instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done1) begin
                if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("dut1 result", result1, e.res);
                    chk("dut1 latency", cyc, e.due);
                    chk("dut1 ready at done", ready1, 0);
                end
            end
        end
    end

    // monitor for the 4-bits-per-cycle instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done4) begin
                if (q4.size() == 0) chk("dut4 unexpected done", 1, 0);
                else begin
                    e = q4.pop_front();
                    chk("dut4 result", result4, e.res);
                    chk("dut4 latency", cyc, e.due);
                    chk("dut4 ready at done", ready4, 0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int nn;
        repeat (3) @(negedge clk);
        chk("reset ready1", ready1, 1);
        chk("reset ready4", ready4, 1);
        chk("reset done1", done1, 0);
        chk("reset done4", done4, 0);
        chk("reset result1", result1, 0);
        chk("reset result4", result4, 0);
        rst = 0;

        issue(13, 7, 5, 7);
        issue(13, 7, 5, 1);
        issue(255, 254, 254, 7);
        issue(255, 0, 254, 7);
        issue(13, 7, 5, 15);
        issue(13, 255, 5, 8);
        issue(1, 200, 0, 7);

        issue(13, 7, 5, 7);
        @(negedge clk);
        n = 11; a = 3; b = 4; k = 1; start = 1;
        @(negedge clk);
        start = 0;
        wait_idle();
        chk("ignored start result1", result1, 9);
        chk("ignored start result4", result4, 9);

        issue(13, 7, 5, 7);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        q1.delete();
        q4.delete();
        chk("mid reset ready1", ready1, 1);
        chk("mid reset ready4", ready4, 1);
        chk("mid reset result1", result1, 0);
        chk("mid reset result4", result4, 0);
        repeat (12) @(negedge clk);
        chk("no done after reset", int'(done1 || done4), 0);

`ifdef MOD_PRODUCT_ABORT_EN
        issue(13, 7, 5, 7);
        issue(11, 3, 4, 7);
        @(negedge clk);
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        q1.delete();
        q4.delete();
        chk("abort ready1", ready1, 1);
        chk("abort ready4", ready4, 1);
        chk("abort result1", result1, 9);
        chk("abort result4", result4, 9);
        issue(11, 3, 4, 7);
`endif

        for (int i = 0; i < 40; i++) begin
            nn = int'($urandom_range(1, 255));
            issue(nn, int'($urandom_range(0, 255)), int'($urandom_range(0, nn - 1)),
                  int'($urandom_range(0, 15)));
        end

        wait_idle();
        chk("queue1 drained", q1.size(), 0);
        chk("queue4 drained", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
